irrigation_scheduler: RTL and testbench

- Sequential controller that owns the three actuators: fill valve ve, drip valve vs and sprinkler pump bs.
- Arbitrates the drip and spray requests from the irrigation decision logic against tank level, so at most one actuator is on at any time.
- Enforces minimum and maximum run times, a rest interval after each watering phase, and a fill timeout.
- Exports a state code and phase-elapsed seconds as two BCD digits for the 7-segment path and the LED matrix.

---
 rtl/irrigation_pkg.sv | 31 +++
 rtl/irrigation_scheduler_if.sv | 37 +++
 rtl/irrigation_scheduler_phase_timer.sv | 67 ++++++
 rtl/irrigation_scheduler.sv | 144 ++++++++++++++
 tb/tb_irrigation_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_pkg.sv
// ============================================================================
// Module      : irrigation_pkg
// Description : Shared state codes, enum and BCD constants for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irrigation_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_DRIP  = 3'd2;
    localparam logic [2:0] S_SPRAY = 3'd3;
    localparam logic [2:0] S_REST  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam int BCD_W   = 4;
    localparam int SEC_SAT = 99;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_FILL  = S_FILL,
        ST_DRIP  = S_DRIP,
        ST_SPRAY = S_SPRAY,
        ST_REST  = S_REST,
        ST_FAULT = S_FAULT
    } state_e;

endpackage

`default_nettype wire

// File: rtl/irrigation_scheduler_if.sv
// ============================================================================
// Module      : irrigation_scheduler_if
// Description : Sensor/request inputs and actuator/display outputs bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irrigation_scheduler_if;
    import irrigation_pkg::*;

    logic             lvl_h;
    logic             lvl_m;
    logic             lvl_l;
    logic             req_drip;
    logic             req_spray;
    logic             nivel_erro;
    logic             ve;
    logic             vs;
    logic             bs;
    logic [2:0]       state;
    logic [BCD_W-1:0] sec_dez;
    logic [BCD_W-1:0] sec_uni;
    logic             fault;

    modport master (
        output lvl_h, lvl_m, lvl_l, req_drip, req_spray, nivel_erro,
        input  ve, vs, bs, state, sec_dez, sec_uni, fault
    );

    modport slave (
        input  lvl_h, lvl_m, lvl_l, req_drip, req_spray, nivel_erro,
        output ve, vs, bs, state, sec_dez, sec_uni, fault
    );

endinterface

`default_nettype wire

// File: rtl/irrigation_scheduler_phase_timer.sv
// ============================================================================
// Module      : phase_timer
// Description : Free-running 1 s tick divider and saturating BCD phase timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    output logic                  tick,
    output logic [BCD_W-1:0]      bcd_dez,
    output logic [BCD_W-1:0]      bcd_uni,
    output logic [6:0]            sec
);

    localparam int              DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(TICK_DIV - 1);
    localparam logic [6:0]      c_sat      = 7'(SEC_SAT);

    logic [DIV_W-1:0] r_div;
    logic [BCD_W-1:0] r_dez;
    logic [BCD_W-1:0] r_uni;
    logic             w_sat;

    assign tick    = (r_div == c_div_last);
    assign sec     = 7'(r_dez) * 7'd10 + 7'(r_uni);
    assign w_sat   = (sec == c_sat);
    assign bcd_dez = r_dez;
    assign bcd_uni = r_uni;

    // Divider never restarts on a phase change, so the first second of a phase may be short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dez <= '0;
            r_uni <= '0;
        end else if (clear) begin
            r_dez <= '0;
            r_uni <= '0;
        end else if (tick && !w_sat) begin
            if (r_uni == 4'd9) begin
                r_uni <= '0;
                r_dez <= r_dez + 1'b1;
            end else begin
                r_uni <= r_uni + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irrigation_scheduler.sv
// ============================================================================
// Module      : irrigation_scheduler
// Description : Tank/irrigation actuator arbiter with run-time limits and fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MIN_ON   = 5,
    parameter int MAX_ON   = 60,
    parameter int REST_T   = 10,
    parameter int FILL_MAX = 90
) (
    input  wire logic               clk,
    input  wire logic               reset,
    irrigation_scheduler_if.slave   bus
);

    localparam logic [6:0] c_min_on   = 7'(MIN_ON);
    localparam logic [6:0] c_max_on   = 7'(MAX_ON);
    localparam logic [6:0] c_rest_t   = 7'(REST_T);
    localparam logic [6:0] c_fill_max = 7'(FILL_MAX);

    logic [5:0]       r_sync1;
    logic [5:0]       r_sync2;
    logic             w_lvl_h, w_lvl_m, w_lvl_l, w_req_drip, w_req_spray, w_err;
    state_e           r_state;
    state_e           w_next;
    logic             w_clear;
    logic             w_tick;
    logic [BCD_W-1:0] w_dez;
    logic [BCD_W-1:0] w_uni;
    logic [6:0]       w_sec;
    logic             r_ve, r_vs, r_bs, r_fault;
    logic [2:0]       r_state_out;
    logic [BCD_W-1:0] r_dez_out;
    logic [BCD_W-1:0] r_uni_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.lvl_h, bus.lvl_m, bus.lvl_l,
                        bus.req_drip, bus.req_spray, bus.nivel_erro};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_lvl_h, w_lvl_m, w_lvl_l, w_req_drip, w_req_spray, w_err} = r_sync2;

    assign w_clear = (w_next != r_state);

    phase_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .tick    (w_tick),
        .bcd_dez (w_dez),
        .bcd_uni (w_uni),
        .sec     (w_sec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_err) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_lvl_l)                        w_next = ST_FILL;
                    else if (w_req_spray && w_lvl_m)     w_next = ST_SPRAY;
                    else if (w_req_drip)                 w_next = ST_DRIP;
                end
                ST_FILL: begin
                    if (w_lvl_h)                         w_next = ST_IDLE;
                    else if (w_sec >= c_fill_max)        w_next = ST_FAULT;
                end
                // An empty tank ends a watering phase even before the minimum run time.
                ST_DRIP: begin
                    if (!w_lvl_l)                                w_next = ST_REST;
                    else if ((w_sec >= c_min_on) && !w_req_drip) w_next = ST_REST;
                    else if (w_sec >= c_max_on)                  w_next = ST_REST;
                end
                ST_SPRAY: begin
                    if (!w_lvl_l)                                 w_next = ST_REST;
                    else if ((w_sec >= c_min_on) && !w_req_spray) w_next = ST_REST;
                    else if (w_sec >= c_max_on)                   w_next = ST_REST;
                end
                ST_REST: begin
                    if (w_sec >= c_rest_t)               w_next = ST_IDLE;
                end
                ST_FAULT: begin
                    if (w_tick && (w_sec >= 7'd1))       w_next = ST_IDLE;
                end
                default:                                 w_next = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ve        <= 1'b0;
            r_vs        <= 1'b0;
            r_bs        <= 1'b0;
            r_fault     <= 1'b0;
            r_state_out <= S_IDLE;
            r_dez_out   <= '0;
            r_uni_out   <= '0;
        end else begin
            r_ve        <= (r_state == ST_FILL);
            r_vs        <= (r_state == ST_DRIP);
            r_bs        <= (r_state == ST_SPRAY);
            r_fault     <= (r_state == ST_FAULT);
            r_state_out <= r_state;
            r_dez_out   <= w_dez;
            r_uni_out   <= w_uni;
        end
    end

    assign bus.ve      = r_ve;
    assign bus.vs      = r_vs;
    assign bus.bs      = r_bs;
    assign bus.fault   = r_fault;
    assign bus.state   = r_state_out;
    assign bus.sec_dez = r_dez_out;
    assign bus.sec_uni = r_uni_out;

endmodule

`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
// ============================================================================
// Module      : tb_irrigation_scheduler
// Description : Directed vector table plus multi-cycle sequences for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irrigation_scheduler;
    import irrigation_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    irrigation_scheduler_if bus();

    irrigation_scheduler #(
        .TICK_DIV (4),
        .MIN_ON   (2),
        .MAX_ON   (5),
        .REST_T   (3),
        .FILL_MAX (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       h, m, l, d, s, e;
        logic [2:0] st;
        logic       ve, vs, bs, flt;
    } vec_t;

    vec_t vt[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic h, m, l, d, s, e);
        bus.lvl_h      = h;
        bus.lvl_m      = m;
        bus.lvl_l      = l;
        bus.req_drip   = d;
        bus.req_spray  = s;
        bus.nivel_erro = e;
    endtask

    task automatic do_reset(input logic h, m, l);
        reset = 1'b0;
        set_in(h, m, l, 1'b0, 1'b0, 1'b0);
        cyc(2);
        reset = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, output int n);
        n = 0;
        while (bus.state !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_uni(input logic [3:0] val, input int budget, output int n);
        n = 0;
        while (bus.sec_uni !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        int seen[$];

        //       h     m     l     d     s     e     st     ve    vs    bs    flt
        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        chk("reset_outputs", {bus.state, bus.ve, bus.vs, bus.bs, bus.fault,
                              bus.sec_dez, bus.sec_uni}, 0);

        // IDLE decision table, each vector applied from a settled full-tank IDLE
        for (int i = 0; i < 10; i++) begin
            do_reset(1'b1, 1'b1, 1'b1);
            cyc(8);
            set_in(vt[i].h, vt[i].m, vt[i].l, vt[i].d, vt[i].s, vt[i].e);
            cyc(5);
            chk($sformatf("vec%0d", i), {bus.state, bus.ve, bus.vs, bus.bs, bus.fault},
                {vt[i].st, vt[i].ve, vt[i].vs, vt[i].bs, vt[i].flt});
        end

        // Empty tank after reset fills, then high level returns to IDLE
        do_reset(1'b0, 1'b0, 1'b0);
        cyc(4);
        chk("fill_state", bus.state, 1);
        chk("fill_ve", bus.ve, 1);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2);
        chk("fill_hold_sync", bus.state, 1);
        cyc(2);
        chk("fill_done", {bus.state, bus.ve}, 0);

        // Both requests: spray wins, runs to MAX_ON, then REST counts 0..3
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_state(3, 8, n);
        chk_rng("spray_latency", n, 3, 4);
        chk("spray_act", {bus.ve, bus.vs, bus.bs}, 3'b001);
        wait_state(4, 30, n);
        chk_rng("spray_max_on", n, 18, 21);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        last = -1;
        n = 0;
        while (bus.state === 3'd4 && n < 30) begin
            if (int'(bus.sec_uni) != last) begin
                seen.push_back(int'(bus.sec_uni));
                last = int'(bus.sec_uni);
            end
            @(negedge clk);
            n++;
        end
        chk_rng("rest_len", n, 10, 13);
        chk("rest_digit_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk($sformatf("rest_digit%0d", i), seen[i], i);
        end
        chk("rest_to_idle", {bus.state, bus.sec_dez, bus.sec_uni}, 0);

        // One-tick drip pulse still holds the valve for MIN_ON
        cyc(2);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drip_entered", {bus.state, bus.vs}, {3'd2, 1'b1});
        wait_state(4, 20, n);
        chk_rng("drip_min_on", n, 6, 9);
        chk("drip_off", bus.vs, 0);
        wait_state(0, 20, n);
        chk_rng("drip_rest", n, 10, 13);

        // Tank empties during drip before MIN_ON: REST, then FILL
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_state(2, 8, n);
        chk_rng("drip2_latency", n, 3, 4);
        wait_uni(4'd1, 10, n);
        chk_rng("drip2_one_sec", n, 0, 9);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("empty_hold_sync", bus.vs, 1);
        cyc(2);
        chk("empty_rest", {bus.state, bus.vs}, {3'd4, 1'b0});
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_state(1, 30, n);
        chk_rng("rest_then_fill", n, 11, 14);
        chk("refill_ve", bus.ve, 1);

        // Fill timeout to FAULT, then recovery on a later tick
        wait_state(5, 40, n);
        chk_rng("fill_timeout", n, 22, 25);
        chk("fill_fault", {bus.fault, bus.ve}, 2'b10);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(0, 20, n);
        chk_rng("fault_recover", n, 2, 8);
        chk("fault_cleared", bus.fault, 0);

        // Level error during spray overrides MIN_ON; timer then saturates at 99
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_state(3, 8, n);
        chk_rng("spray2_latency", n, 3, 4);
        wait_uni(4'd1, 10, n);
        chk_rng("spray2_one_sec", n, 0, 9);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_state(5, 6, n);
        chk_rng("err_latency", n, 2, 4);
        chk("err_outputs", {bus.bs, bus.fault}, 2'b01);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(440);
        chk("sat_digits", {bus.state, bus.sec_dez, bus.sec_uni}, {3'd5, 4'd9, 4'd9});

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", {bus.state, bus.ve, bus.vs, bus.bs, bus.fault,
                            bus.sec_dez, bus.sec_uni}, 0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2);
        reset = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
